audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameters SHALL be none; all ratios are fixed for a 100 MHz clk.
REQ-002 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 in_valid  input  1  producer offers a stereo sample pair.
REQ-005 in_left  input  16  left sample, two's complement (mixer output).
REQ-006 in_right  input  16  right sample, two's complement.
REQ-007 in_ready  output  1  holding register empty, sample can be accepted.
REQ-008 audio_mclk  output  1  DAC master clock, clk/4.
REQ-009 audio_lrck  output  1  word select, clk/512; 0 = left, 1 = right.
REQ-010 audio_sck  output  1  serial bit clock, clk/16.
REQ-011 audio_sdin  output  1  serial data, I2S format, MSB first.
REQ-012 underrun  output  1  one-cycle pulse: frame started with no new sample.

Function
REQ-013 A free-running 9-bit counter cnt SHALL increment every cycle and wrap 511->0.
REQ-014 audio_mclk SHALL equal cnt[1], audio_sck SHALL equal cnt[3], and audio_lrck SHALL equal cnt[8], each driven from a register.
REQ-015 Slot index s = cnt[8:4] (0..31); one slot is one SCK period (16 clk).
REQ-016 A frame boundary SHALL occur on the cycle cnt changes 511->0.
REQ-017 The block SHALL hold a one-entry holding register (32 bits plus a full flag).
REQ-018 in_ready SHALL be the inverse of the full flag, with no combinational path from in_valid.
REQ-019 A transfer SHALL occur when in_valid && in_ready on a rising edge. {in_left,in_right} is captured and full is set.
REQ-020 At a frame boundary with full=1, frame_word SHALL load from the holding register and full SHALL clear.
REQ-021 At a frame boundary with full=0, frame_word SHALL keep its value and underrun SHALL pulse high for exactly that cycle.
REQ-022 Simultaneous transfer and boundary with full=0: the new sample SHALL go to the holding register, not frame_word, and underrun still pulses.
REQ-023 At a frame boundary with full=1, in_ready is 0, so no transfer is possible in that cycle.
REQ-024 audio_sdin SHALL update only on the cycle where cnt[3:0] changes 1111->0000 (SCK falling edge).
REQ-025 In slot s>=1, sdin SHALL carry frame_word[32-s]: slots 1-16 carry left bits 15..0 and slots 17-31 carry right bits 15..1.
REQ-026 In slot 0, sdin SHALL carry the previous frame's right bit 0 (I2S one-bit delay). That bit is kept in a dedicated register.
REQ-027 First audible left MSB latency: the slot-1 falling edge after the boundary that loads the sample, which is 16 clk after the boundary.

Reset
REQ-028 While rst=0: cnt=0, full=0, in_ready=1, frame_word=0, saved LSB=0, audio_mclk/lrck/sck/sdin=0, underrun=0.
REQ-029 Reset mid-frame SHALL discard holding and frame contents. No partial word is sent after release.
REQ-030 After rst rises, the first frame boundary SHALL occur 512 cycles later.

Configuration
REQ-031 Macro I2S_TX_UNDERRUN_ZERO_EN selects underrun behaviour.
- Defined: on an underrun boundary, frame_word SHALL load 32'h0 (silence).
- Undefined: frame_word SHALL repeat the previous sample (REQ-021).
- The underrun pulse is identical in both builds.

Verification
REQ-032 Release reset, in_valid=0 for 2 frames -> lrck period 512 clk, sck 16 clk, mclk 4 clk; underrun pulses at cycles 512 and 1024; sdin constant 0.
REQ-033 Offer L=16'hA5C3, R=16'h0F01 before the first boundary -> in_ready drops; slots 1-16 shift A5C3 MSB first; slots 17-31 shift 0F01 bits 15..1; next frame slot 0 = 1.
REQ-034 Offer pairs back-to-back with in_valid held at 1 -> exactly one transfer per frame; in_ready high for 1 cycle after each boundary; no underrun; samples serialized in order.
REQ-035 Assert in_valid on exactly the boundary cycle with full=0 -> underrun pulses; sample appears on sdin in the following frame.
REQ-036 Skip one frame after L=16'h7FFF,R=16'h8000 -> with macro defined the skipped frame is all zeros; without it 7FFF/8000 repeats.
REQ-037 Pull rst low at slot 20 with full=1 -> all outputs 0 immediately (async); after release in_ready=1 and the discarded sample never appears.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter for a 100 MHz system clock.
// Produces MCLK (clk/4), SCK (clk/16) and LRCK (clk/512) from a free-running
// 9-bit counter and serializes one 16+16 bit stereo pair per frame, MSB first,
// with the I2S one-bit delay relative to LRCK.
// A one-entry holding register decouples the producer from the frame timing.
// Build option: define I2S_TX_UNDERRUN_ZERO_EN to send silence (all zeros) on
// a frame that starts with no new sample. When it is undefined, the previous
// sample is repeated instead. The underrun pulse is the same in both builds.
module audio_i2s_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  output logic        in_ready,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        underrun
);

  logic [8:0]  r_cnt;
  logic        r_mclk;
  logic        r_lrck;
  logic        r_sck;
  logic        r_full;
  logic [31:0] r_hold;
  logic [31:0] r_frame;
  logic        r_lsb;
  logic        r_sdin;
  logic        r_underrun;

  logic [8:0]  w_cnt_next;
  logic        w_boundary;
  logic        w_xfer;
  logic        w_sck_fall;
  logic [4:0]  w_slot_next;
  logic [4:0]  w_bit_idx;

  assign w_cnt_next  = r_cnt + 9'd1;
  // The last cycle of a frame: the next edge wraps the counter to 0.
  assign w_boundary  = (r_cnt == 9'd511);
  // in_ready comes straight from the full flag, never from in_valid.
  assign w_xfer      = in_valid & ~r_full;
  // SCK falls when the low nibble wraps; that is when a new bit goes out.
  assign w_sck_fall  = (r_cnt[3:0] == 4'hF);
  assign w_slot_next = w_cnt_next[8:4];
  // Slot s carries frame bit 32-s; modulo 32 this is simply -s.
  assign w_bit_idx   = 5'd0 - w_slot_next;

  // Free-running counter; the clock outputs are registered copies of its bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 9'd0;
      r_mclk <= 1'b0;
      r_sck  <= 1'b0;
      r_lrck <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_mclk <= w_cnt_next[1];
      r_sck  <= w_cnt_next[3];
      r_lrck <= w_cnt_next[8];
    end
  end

  // Holding register, frame word and underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full     <= 1'b0;
      r_hold     <= 32'd0;
      r_frame    <= 32'd0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_boundary & ~r_full;
      if (w_boundary && r_full) begin
        // in_ready is low here, so no capture can collide with this load.
        r_frame <= r_hold;
        r_full  <= 1'b0;
      end else begin
        if (w_boundary) begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
          r_frame <= 32'd0;
`else
          r_frame <= r_frame;
`endif
        end
        // A sample arriving on an empty-boundary cycle waits for the next frame.
        if (w_xfer) begin
          r_hold <= {in_left, in_right};
          r_full <= 1'b1;
        end
      end
    end
  end

  // Serializer: one bit per SCK falling edge, right LSB delayed into slot 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sdin <= 1'b0;
      r_lsb  <= 1'b0;
    end else if (w_sck_fall) begin
      if (w_slot_next == 5'd0) begin
        r_sdin <= r_lsb;
      end else begin
        r_sdin <= r_frame[w_bit_idx];
      end
      // Keep the right LSB before the frame word may be reloaded.
      if (w_slot_next == 5'd31) begin
        r_lsb <= r_frame[0];
      end
    end
  end

  assign in_ready   = ~r_full;
  assign audio_mclk = r_mclk;
  assign audio_sck  = r_sck;
  assign audio_lrck = r_lrck;
  assign audio_sdin = r_sdin;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized self-checking bench for audio_i2s_tx.
// The reference model tracks position in the frame, the pending sample and the
// word being sent, and derives every output value from the frame position
// with plain arithmetic. Honours I2S_TX_UNDERRUN_ZERO_EN like the design.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = 16'd0;
  logic [15:0] in_right = 16'd0;
  logic        in_ready;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        underrun;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [8:0]  m_cnt = 9'd0;   // position within the frame
  logic        m_full = 1'b0;  // a sample is waiting
  logic [31:0] m_hold = 32'd0;
  logic [31:0] m_word = 32'd0; // word of the current frame
  logic        m_lsb = 1'b0;   // right LSB of the previous frame
  logic        m_und = 1'b0;
  logic        m_last_xfer = 1'b0;

  audio_i2s_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_left    (in_left),
    .in_right   (in_right),
    .in_ready   (in_ready),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 9'd0; m_full = 1'b0; m_hold = 32'd0; m_word = 32'd0;
    m_lsb = 1'b0; m_und = 1'b0; m_last_xfer = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT saw.
  task automatic model_edge();
    logic bnd;
    logic xfer;
    if (!rst) begin
      model_reset();
    end else begin
      bnd   = (m_cnt == 9'd511);
      xfer  = in_valid && !m_full;
      m_und = bnd && !m_full;
      if (bnd) begin
        m_lsb = m_word[0];
        if (m_full) begin
          m_word = m_hold;
          m_full = 1'b0;
        end else begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
          m_word = 32'd0;
`endif
        end
      end
      if (xfer) begin
        m_hold = {in_left, in_right};
        m_full = 1'b1;
        $display("XFER t=%0t L=%h R=%h", $time, in_left, in_right);
      end
      m_last_xfer = xfer;
      m_cnt = m_cnt + 9'd1;
    end
  endtask

  function automatic logic exp_sdin();
    int s;
    s = int'(m_cnt[8:4]);
    if (s == 0) return m_lsb;
    return m_word[32 - s];
  endfunction

  task automatic check_outputs();
    chk("mclk",     32'(audio_mclk), 32'(m_cnt[1]));
    chk("sck",      32'(audio_sck),  32'(m_cnt[3]));
    chk("lrck",     32'(audio_lrck), 32'(m_cnt[8]));
    chk("sdin",     32'(audio_sdin), 32'(exp_sdin()));
    chk("in_ready", 32'(in_ready),   32'(!m_full));
    chk("underrun", 32'(underrun),   32'(m_und));
  endtask

  // One clock: edge, model update, then check on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_for(input logic [8:0] target, input bit need_empty, input int budget);
    int n;
    n = 0;
    while (!(m_cnt == target && (!need_empty || !m_full)) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int n_und;
    int n_sdin_hi;

    // Reset state
    rst = 1'b0;
    repeat (4) tick();
    rst = 1'b1;

    // Idle for two frames: underrun at 512 and 1024, sdin stays 0
    n_und = 0;
    n_sdin_hi = 0;
    repeat (1024) begin
      tick();
      n_und += int'(underrun);
      n_sdin_hi += int'(audio_sdin);
    end
    chk("idle_underruns", 32'(n_und), 32'(2));
    chk("idle_sdin_high", 32'(n_sdin_hi), 32'(0));

    // Single known sample before the next boundary
    in_valid = 1'b1; in_left = 16'hA5C3; in_right = 16'h0F01;
    tick();
    in_valid = 1'b0;
    chk("a5c3_ready_low", 32'(in_ready), 32'(0));
    repeat (1100) tick();

    // Back-to-back: in_valid held high, new data after every transfer
    in_valid = 1'b1;
    in_left = 16'($urandom); in_right = 16'($urandom);
    tick();
    in_left = 16'($urandom); in_right = 16'($urandom);
    n_und = 0;
    repeat (4 * 512) begin
      tick();
      n_und += int'(underrun);
      if (m_last_xfer) begin
        in_left = 16'($urandom); in_right = 16'($urandom);
      end
    end
    chk("b2b_underruns", 32'(n_und), 32'(0));
    in_valid = 1'b0;

    // Offer only on the boundary cycle with the holding register empty
    wait_for(9'd511, 1'b1, 2000);
    in_valid = 1'b1; in_left = 16'($urandom); in_right = 16'($urandom);
    tick();
    in_valid = 1'b0;
    chk("bnd_underrun", 32'(underrun), 32'(1));
    chk("bnd_captured", 32'(in_ready), 32'(0));
    repeat (1100) tick();

    // Known sample followed by a skipped frame
    wait_for(9'd100, 1'b1, 2000);
    in_valid = 1'b1; in_left = 16'h7FFF; in_right = 16'h8000;
    tick();
    in_valid = 1'b0;
    repeat (3 * 512) tick();

    // Random traffic
    repeat (3000) begin
      in_valid = ($urandom_range(0, 299) == 0);
      in_left = 16'($urandom); in_right = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;

    // Reset at slot 20 with a sample waiting
    wait_for(9'd1, 1'b1, 2000);
    in_valid = 1'b1; in_left = 16'($urandom); in_right = 16'($urandom);
    tick();
    in_valid = 1'b0;
    wait_for(9'd320, 1'b0, 600);
    chk("pre_rst_full", 32'(in_ready), 32'(0));
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) tick();
    rst = 1'b1;
    n_sdin_hi = 0;
    repeat (1100) begin
      tick();
      n_sdin_hi += int'(audio_sdin);
    end
    chk("post_rst_sdin_high", 32'(n_sdin_hi), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
